// File: rtl/memory_stage.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ack handshake,
// formats load data, and registers results into the MEM/WB pipeline register.
module memory_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:8]  ctrl,
  input  logic [0:31] alu_out,
  input  logic [0:31] write_data,
  input  logic [0:2]  dmem_info,
  input  logic [0:4]  write_reg,
  input  logic [0:31] dmem_rdata,
  input  logic        dmem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [0:31] dmem_addr,
  output logic [0:31] dmem_wdata,
  output logic [0:3]  dmem_be,
  output logic        stall,
  output logic [0:8]  ctrl_wb,
  output logic [0:31] alu_out_wb,
  output logic [0:31] load_data_wb,
  output logic [0:4]  write_reg_wb,
  output logic        misalign,
  output logic        dmem_err
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [0:31]        addr_q, addr_d;
  logic [0:31]        wdata_q, wdata_d;
  logic [0:3]         be_q, be_d;
  logic [0:2]         info_q, info_d;
  logic [0:1]         off_q, off_d;
  logic [0:31]        ld_q, ld_d;
  logic [0:8]         ctrl_wb_q, ctrl_wb_d;
  logic [0:31]        alu_wb_q, alu_wb_d;
  logic [0:31]        ldwb_q, ldwb_d;
  logic [0:4]         wreg_wb_q, wreg_wb_d;
  logic               mis_q, mis_d;
  logic               err_q, err_d;
  logic               stall_c;

  logic               mem_op;
  logic               mis_op;
  logic [0:1]         off;

  // sz encoding: 00 byte, 01 half, 1x word
  function automatic logic is_misaligned(input logic [0:1] k, input logic [0:1] sz);
    logic r;
    r = 1'b0;
    if (sz == 2'b01)   r = k[1];
    else if (sz[0])    r = (k != 2'b00);
    return r;
  endfunction

  function automatic logic [0:3] byte_en(input logic [0:1] k, input logic [0:1] sz);
    logic [0:3] be;
    case (sz)
      2'b00:   be = 4'b1000 >> k;
      2'b01:   be = k[0] ? 4'b0011 : 4'b1100;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [0:31] store_data(input logic [0:31] wd, input logic [0:1] sz);
    logic [0:31] r;
    case (sz)
      2'b00:   r = {4{wd[24:31]}};
      2'b01:   r = {2{wd[16:31]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Big-endian lane select, then sign or zero extension into a full word
  function automatic logic [0:31] load_fmt(input logic [0:31] rd, input logic [0:1] k,
                                           input logic [0:2] info);
    logic [0:7]  b;
    logic [0:15] h;
    logic [0:31] r;
    case (k)
      2'b00:   b = rd[0:7];
      2'b01:   b = rd[8:15];
      2'b10:   b = rd[16:23];
      default: b = rd[24:31];
    endcase
    h = k[0] ? rd[16:31] : rd[0:15];
    case (info[1:2])
      2'b00:   r = info[0] ? {24'h000000, b} : {{24{b[0]}}, b};
      2'b01:   r = info[0] ? {16'h0000, h}   : {{16{h[0]}}, h};
      default: r = rd;
    endcase
    return r;
  endfunction

  assign mem_op = ctrl[2] | ctrl[3];
  assign off    = alu_out[30:31];
  assign mis_op = mem_op & is_misaligned(off, dmem_info[1:2]);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    info_d    = info_q;
    off_d     = off_q;
    ld_d      = ld_q;
    ctrl_wb_d = ctrl_wb_q;
    alu_wb_d  = alu_wb_q;
    ldwb_d    = ldwb_q;
    wreg_wb_d = wreg_wb_q;
    mis_d     = mis_q;
    err_d     = err_q;
    stall_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && !mis_op) begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = ctrl[3];
          addr_d  = {alu_out[0:29], 2'b00};
          wdata_d = store_data(write_data, dmem_info[1:2]);
          be_d    = byte_en(off, dmem_info[1:2]);
          info_d  = dmem_info;
          off_d   = off;
          cnt_d   = '0;
          ld_d    = '0;
          stall_c = 1'b1;
        end else begin
          // A misaligned access retires as a non-memory op that cannot write back
          ctrl_wb_d = ctrl;
          if (mis_op) begin
            ctrl_wb_d[4] = 1'b0;
            mis_d        = 1'b1;
          end
          alu_wb_d  = alu_out;
          ldwb_d    = '0;
          wreg_wb_d = write_reg;
        end
      end
      REQ: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          ld_d    = we_q ? 32'h0 : load_fmt(dmem_rdata, off_q, info_q);
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          ld_d    = '0;
        end
      end
      DONE: begin
        // Upstream is still frozen on this access, so its inputs are current
        ctrl_wb_d = ctrl;
        alu_wb_d  = alu_out;
        ldwb_d    = ld_q;
        wreg_wb_d = write_reg;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      info_q    <= '0;
      off_q     <= '0;
      ld_q      <= '0;
      ctrl_wb_q <= '0;
      alu_wb_q  <= '0;
      ldwb_q    <= '0;
      wreg_wb_q <= '0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      info_q    <= info_d;
      off_q     <= off_d;
      ld_q      <= ld_d;
      ctrl_wb_q <= ctrl_wb_d;
      alu_wb_q  <= alu_wb_d;
      ldwb_q    <= ldwb_d;
      wreg_wb_q <= wreg_wb_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
    end
  end

  // stall is masked by reset so a held memory op cannot freeze upstream during reset
  assign stall        = rst_n & stall_c;
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign ctrl_wb      = ctrl_wb_q;
  assign alu_out_wb   = alu_wb_q;
  assign load_data_wb = ldwb_q;
  assign write_reg_wb = wreg_wb_q;
  assign misalign     = mis_q;
  assign dmem_err     = err_q;

endmodule
